// File: rtl/mux_8to1.sv
// ---------------------------------------------------------------------------
// mux_8to1
//   Eight-input, one-bit selector. `out` is the purely combinational
//   data[sel]. An optional shadow register path provides a one-cycle-late
//   copy of the selected bit, the registered select and a select-change
//   strobe.
//
//   Build option: define MUX8TO1_REG_PATH_EN to build the register path.
//   Without it, no flops exist: out_q follows out, sel_q follows sel,
//   sel_chg_q is held at 0, and clk/rst_n are left unused.
//
// Ports
//   clk        in   1  clock, rising-edge active
//   rst_n      in   1  synchronous active-low reset
//   data       in   8  candidate bits; bit i chosen when sel == i
//   sel        in   3  select index 0..7
//   out        out  1  combinational data[sel]
//   out_q      out  1  data[sel] registered one cycle late
//   sel_q      out  3  sel registered one cycle late
//   sel_chg_q  out  1  one-cycle strobe: sel differed from sel_q at last edge
// ---------------------------------------------------------------------------
module mux_8to1 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic [2:0] sel,
  output logic       out,
  output logic       out_q,
  output logic [2:0] sel_q,
  output logic       sel_chg_q
);

  // Indexing by sel reads only the addressed bit, so X/Z on any other
  // data bit cannot reach the output.
  logic w_sel_bit;
  assign w_sel_bit = data[sel];
  assign out       = w_sel_bit;

`ifdef MUX8TO1_REG_PATH_EN
  logic       r_out_q;
  logic [2:0] r_sel_q;
  logic       r_sel_chg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_q     <= 1'b0;
      r_sel_q     <= 3'd0;
      r_sel_chg_q <= 1'b0;
    end else begin
      r_out_q     <= w_sel_bit;
      r_sel_q     <= sel;
      // Compared against the registered select, so the first edge after
      // reset flags any nonzero sel.
      r_sel_chg_q <= (sel != r_sel_q);
    end
  end

  assign out_q     = r_out_q;
  assign sel_q     = r_sel_q;
  assign sel_chg_q = r_sel_chg_q;
`else
  // Flop-free build: clk and rst_n are kept only so the port list is
  // identical in both builds.
  logic w_unused;
  assign w_unused  = &{1'b0, clk, rst_n};

  assign out_q     = w_sel_bit;
  assign sel_q     = sel;
  assign sel_chg_q = 1'b0;
`endif

endmodule

// File: tb/tb_mux_8to1.sv
module tb_mux_8to1;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic [2:0] sel;
  logic       out;
  logic       out_q;
  logic [2:0] sel_q;
  logic       sel_chg_q;

  mux_8to1 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data),
    .sel       (sel),
    .out       (out),
    .out_q     (out_q),
    .sel_q     (sel_q),
    .sel_chg_q (sel_chg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       o;
    logic       oq;
    logic [2:0] sq;
    logic       chg;
  } exp_t;

  exp_t q_exp[$];

  int checks = 0;
  int errors = 0;

  // reference state of the register path
  logic       m_out_q;
  logic [2:0] m_sel_q;
  logic       m_chg;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d data=%b rst_n=%b)",
               tag, got, exp, $time, sel, data, rst_n);
    end
  endtask

  // Expected values from the current inputs and the reference state.
  task automatic push_exp();
    exp_t e;
    logic [7:0] d;
    d     = data;
    e.o   = d[sel];
`ifdef MUX8TO1_REG_PATH_EN
    e.oq  = m_out_q;
    e.sq  = m_sel_q;
    e.chg = m_chg;
`else
    e.oq  = d[sel];
    e.sq  = sel;
    e.chg = 1'b0;
`endif
    q_exp.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (q_exp.size() == 0) begin
      chk({tag, "_queue_empty"}, 8'd1, 8'd0);
    end else begin
      e = q_exp.pop_front();
      chk({tag, "_out"},   {7'd0, out},       {7'd0, e.o});
      chk({tag, "_out_q"}, {7'd0, out_q},     {7'd0, e.oq});
      chk({tag, "_sel_q"}, {5'd0, sel_q},     {5'd0, e.sq});
      chk({tag, "_chg"},   {7'd0, sel_chg_q}, {7'd0, e.chg});
    end
  endtask

  task automatic model_edge(input logic [7:0] d, input logic [2:0] s, input logic r);
    if (!r) begin
      m_out_q = 1'b0;
      m_sel_q = 3'd0;
      m_chg   = 1'b0;
    end else begin
      m_out_q = d[s];
      m_chg   = (s != m_sel_q);
      m_sel_q = s;
    end
  endtask

  // Drive on the falling edge, check combinational response, then check the
  // registered response just after the following rising edge.
  task automatic cycle(input logic [7:0] d, input logic [2:0] s, input logic r, input string tag);
    @(negedge clk);
    data  = d;
    sel   = s;
    rst_n = r;
    #1;
    push_exp();
    pop_cmp({tag, "_pre"});
    @(posedge clk);
    model_edge(d, s, r);
    #1;
    push_exp();
    pop_cmp({tag, "_post"});
  endtask

  initial begin
    logic [7:0] d;
    rst_n = 1'b0;
    data  = 8'h00;
    sel   = 3'd0;
    @(posedge clk);
    model_edge(data, sel, 1'b0);

    // reset held two edges: out live, registers cleared
    cycle(8'hFF, 3'd5, 1'b0, "rst0");
    cycle(8'hFF, 3'd5, 1'b0, "rst1");
    // release: first edge captures sel=5 and flags the change
    cycle(8'hFF, 3'd5, 1'b1, "rel");
    cycle(8'hFF, 3'd5, 1'b1, "rel_hold");

    for (int s = 0; s < 8; s++) cycle(8'b10101010, 3'(s), 1'b1, "alt");
    for (int s = 0; s < 8; s++) cycle(8'h01, 3'(s), 1'b1, "walk01");
    for (int s = 0; s < 8; s++) cycle(8'h80, 3'(s), 1'b1, "walk80");

    // sel 0 -> 3 with data AA
    cycle(8'hAA, 3'd0, 1'b1, "s0");
    cycle(8'hAA, 3'd0, 1'b1, "s0b");
    cycle(8'hAA, 3'd3, 1'b1, "s3");
    cycle(8'hAA, 3'd3, 1'b1, "s3b");

    // sel fixed at 2, toggle data[2]
    for (int i = 0; i < 6; i++) cycle((i % 2) ? 8'h04 : 8'h00, 3'd2, 1'b1, "tog");

    // reset mid-operation coinciding with a sel change: reset wins
    cycle(8'hC3, 3'd6, 1'b0, "midrst");
    cycle(8'hC3, 3'd7, 1'b0, "midrst2");
    cycle(8'hC3, 3'd0, 1'b1, "midrel0");
    cycle(8'hC3, 3'd1, 1'b1, "midrel1");

    // X on unselected bits
    cycle(8'bxxxx_x1xx, 3'd2, 1'b1, "xsel");
    cycle(8'bxx0x_xxxx, 3'd5, 1'b1, "xsel2");

    // random traffic, including back-to-back sel changes
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      cycle(d, 3'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
